// File: rtl/maple_transmitter_if.sv
// AXI4-Stream byte channel feeding the Maple Bus transmitter.
// The master drives payload bytes; the slave (transmitter) answers with TREADY.
interface maple_transmitter_if;
   logic [7:0] TDATA;
   logic       TVALID;
   logic       TLAST;
   logic       TREADY;

   modport master (output TDATA, TVALID, TLAST, input TREADY);
   modport slave  (input TDATA, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/maple_transmitter.sv
// Maple Bus frame transmitter: start pattern, MSB-first data bits and end pattern on SDCKA/SDCKB.
// Every line level is held for CLKS_PER_STEP cycles; the pads are released outside a frame.
module maple_transmitter #(
   parameter int CLKS_PER_STEP    = 4,
   parameter int UNDERRUN_TIMEOUT = 256
) (
   input  logic               S_AXIS_ACLK,
   input  logic               S_AXIS_ARESET,
   maple_transmitter_if.slave s_axis,
   input  logic [1:0]         MODE,
   input  logic               ENABLE,
   output logic               SDCKA_O,
   output logic               SDCKB_O,
   output logic               SDCK_OE,
   output logic               TRANSMITTING,
   output logic               UNDERRUN
);
   localparam int CW = $clog2(CLKS_PER_STEP);
   localparam int UW = $clog2(UNDERRUN_TIMEOUT + 1);
   localparam logic [CW-1:0] STEP_LAST = CW'(CLKS_PER_STEP - 1);
   localparam logic [UW-1:0] UND_LAST  = UW'(UNDERRUN_TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_LOAD, S_DATA, S_END, S_GUARD} state_t;

   state_t        state_reg;
   logic [CW-1:0] cnt_reg;
   logic [4:0]    idx_reg;
   logic [2:0]    bit_reg;
   logic [3:0]    n_reg;
   logic [7:0]    data_reg;
   logic          last_reg;
   logic [UW-1:0] ucnt_reg;
   logic          a_reg, b_reg, oe_reg, tx_reg, underrun_reg;

   logic          step_done;
   logic [4:0]    idx_inc;
   logic [2:0]    bit_dec;

   assign step_done     = (cnt_reg == STEP_LAST);
   assign idx_inc       = idx_reg + 5'd1;
   assign bit_dec       = bit_reg - 3'd1;
   assign s_axis.TREADY = (state_reg == S_LOAD) && s_axis.TVALID;

   assign SDCKA_O      = a_reg;
   assign SDCKB_O      = b_reg;
   assign SDCK_OE      = oe_reg;
   assign TRANSMITTING = tx_reg;
   assign UNDERRUN     = underrun_reg;

   function automatic logic [3:0] pulse_count(input logic [1:0] m);
      case (m)
         2'b01:   return 4'd6;
         2'b10:   return 4'd14;
         default: return 4'd4;
      endcase
   endfunction

   // Start step i: 0 -> A0B1, then alternating B low/high pulses, last step (2N+1) -> A1B1.
   function automatic logic [1:0] start_level(input logic [4:0] i, input logic [3:0] n);
      if (i == {n, 1'b1})
         return 2'b11;
      else if (i[0])
         return 2'b00;
      else
         return 2'b01;
   endfunction

   // Odd bits strobe on A with data on B, even bits the other way round.
   function automatic logic [1:0] data_level(input logic [2:0] b, input logic [1:0] ph, input logic d);
      logic strobe;
      strobe = (ph != 2'd1);
      return b[0] ? {strobe, d} : {d, strobe};
   endfunction

   function automatic logic [1:0] end_level(input logic [4:0] i);
      case (i)
         5'd1, 5'd3: return 2'b00;
         5'd5:       return 2'b11;
         default:    return 2'b10;
      endcase
   endfunction

   always_ff @(posedge S_AXIS_ACLK) begin
      if (S_AXIS_ARESET) begin
         state_reg    <= S_IDLE;
         cnt_reg      <= '0;
         idx_reg      <= '0;
         bit_reg      <= '0;
         n_reg        <= '0;
         data_reg     <= '0;
         last_reg     <= 1'b0;
         ucnt_reg     <= '0;
         a_reg        <= 1'b1;
         b_reg        <= 1'b1;
         oe_reg       <= 1'b0;
         tx_reg       <= 1'b0;
         underrun_reg <= 1'b0;
      end else begin
         underrun_reg <= 1'b0;
         cnt_reg      <= step_done ? '0 : cnt_reg + CW'(1);
         case (state_reg)
            S_IDLE: begin
               cnt_reg <= '0;
               if (ENABLE && s_axis.TVALID) begin
                  n_reg     <= pulse_count(MODE);
                  idx_reg   <= '0;
                  ucnt_reg  <= '0;
                  a_reg     <= 1'b0;
                  b_reg     <= 1'b1;
                  oe_reg    <= 1'b1;
                  tx_reg    <= 1'b1;
                  state_reg <= S_START;
               end
            end
            S_START: if (step_done) begin
               if (idx_reg == {n_reg, 1'b1}) begin
                  state_reg <= S_LOAD;
               end else begin
                  idx_reg          <= idx_inc;
                  {a_reg, b_reg}   <= start_level(idx_inc, n_reg);
               end
            end
            S_LOAD: begin
               // The load cycle is extra time on the A1B1 level, not a step of its own.
               cnt_reg <= '0;
               if (s_axis.TVALID) begin
                  data_reg       <= s_axis.TDATA;
                  last_reg       <= s_axis.TLAST;
                  ucnt_reg       <= '0;
                  bit_reg        <= 3'd7;
                  idx_reg        <= '0;
                  {a_reg, b_reg} <= data_level(3'd7, 2'd0, s_axis.TDATA[7]);
                  state_reg      <= S_DATA;
               end else if (ucnt_reg == UND_LAST) begin
                  underrun_reg   <= 1'b1;
                  ucnt_reg       <= '0;
                  idx_reg        <= '0;
                  {a_reg, b_reg} <= end_level(5'd0);
                  state_reg      <= S_END;
               end else begin
                  ucnt_reg <= ucnt_reg + UW'(1);
               end
            end
            S_DATA: if (step_done) begin
               if (idx_reg == 5'd2) begin
                  idx_reg <= '0;
                  if (bit_reg != 3'd0) begin
                     bit_reg        <= bit_dec;
                     {a_reg, b_reg} <= data_level(bit_dec, 2'd0, data_reg[bit_dec]);
                  end else if (last_reg) begin
                     {a_reg, b_reg} <= end_level(5'd0);
                     state_reg      <= S_END;
                  end else begin
                     {a_reg, b_reg} <= 2'b11;
                     state_reg      <= S_LOAD;
                  end
               end else begin
                  idx_reg        <= idx_inc;
                  {a_reg, b_reg} <= data_level(bit_reg, idx_inc[1:0], data_reg[bit_reg]);
               end
            end
            S_END: if (step_done) begin
               if (idx_reg == 5'd5) begin
                  idx_reg   <= '0;
                  state_reg <= S_GUARD;
               end else begin
                  idx_reg        <= idx_inc;
                  {a_reg, b_reg} <= end_level(idx_inc);
               end
            end
            S_GUARD: if (step_done) begin
               if (idx_reg == 5'd1) begin
                  idx_reg   <= '0;
                  oe_reg    <= 1'b0;
                  tx_reg    <= 1'b0;
                  state_reg <= S_IDLE;
               end else begin
                  idx_reg <= idx_inc;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end
endmodule
